// File: rtl/mc_control.sv
// mc_control: main control FSM for the multicycle MIPS datapath, with ALU decoder and retired counter.
// Define MC_CONTROL_BNE_EN to decode bne (op 000101) into BNEEX.
module mc_control #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               pcen,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired,
    output logic [STATE_W-1:0] state_dbg
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
    } state_t;

    state_t     state, next;
    logic [1:0] aluop;
    logic       pcwrite, branch, bne_st, bne, irw, mw, rw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state      <= next;
            illegal_op <= (state == DECODE) && (next == FETCH);
            if (next == FETCH && state != DECODE)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = DECODE;
            DECODE:
                case (op)
                    6'b100011, 6'b101011: next = MEMADR;
                    6'b000000:            next = RTYPEEX;
                    6'b000100:            next = BEQEX;
                    6'b001000:            next = ADDIEX;
                    6'b000010:            next = JEX;
`ifdef MC_CONTROL_BNE_EN
                    6'b000101:            next = BNEEX;
`endif
                    default:              next = FETCH;
                endcase
            MEMADR:  next = (op == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:   next = MEMWB;
            RTYPEEX: next = RTYPEWB;
            ADDIEX:  next = ADDIWB;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        irw      = 1'b0;
        mw       = 1'b0;
        pcwrite  = 1'b0;
        rw       = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        branch   = 1'b0;
        bne_st   = 1'b0;
        case (state)
            FETCH:   begin irw = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; end
            DECODE:  alusrcb = 2'b11;
            MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin rw = 1'b1; memtoreg = 1'b1; end
            MEMWR:   begin iord = 1'b1; mw = 1'b1; end
            RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
            RTYPEWB: begin regdst = 1'b1; rw = 1'b1; end
            BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
            ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            ADDIWB:  rw = 1'b1;
            JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
            BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; bne_st = 1'b1; end
            default: ;
        endcase
    end

`ifdef MC_CONTROL_BNE_EN
    assign bne = bne_st;
`else
    assign bne = 1'b0;
`endif

    // Write strobes are gated by reset so an abort cannot leave a partial store behind.
    assign irwrite  = irw & ~reset;
    assign memwrite = mw & ~reset;
    assign regwrite = rw & ~reset;
    assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne & ~zero));

    assign alucontrol = (aluop == 2'b01)     ? 3'b110 :
                        (aluop != 2'b10)     ? 3'b010 :
                        (funct == 6'b100010) ? 3'b110 :
                        (funct == 6'b100100) ? 3'b000 :
                        (funct == 6'b100101) ? 3'b001 :
                        (funct == 6'b101010) ? 3'b111 : 3'b010;

    assign state_dbg = state;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control; expected per-cycle outputs are queued by stimulus.
module tb_mc_control;
    logic        clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0]  op = '0, funct = '0;
    logic        iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal_op;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    typedef struct packed {
        logic [3:0]  st;
        logic        iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca;
        logic [1:0]  alusrcb, pcsrc;
        logic [2:0]  alucontrol;
        logic        illegal;
        logic [31:0] retired;
    } obs_t;

    obs_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] exp_ret = '0;
    logic        pend_ill = 1'b0;

    mc_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic obs_t exp_out(input logic [3:0] s, input logic z, input logic [2:0] ralu);
        obs_t o = '0;
        o.st = s;
        o.alucontrol = 3'b010;
        case (s)
            4'd0:  begin o.irwrite = 1'b1; o.alusrcb = 2'b01; o.pcen = 1'b1; end
            4'd1:  o.alusrcb = 2'b11;
            4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd3:  o.iord = 1'b1;
            4'd4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            4'd6:  begin o.alusrca = 1'b1; o.alucontrol = ralu; end
            4'd7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            4'd8:  begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
            4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            4'd10: o.regwrite = 1'b1;
            4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            4'd12: begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = ~z; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", n, g, x);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic z, input logic [2:0] ralu, input logic ill);
        obs_t e;
        e = exp_out(s, z, ralu);
        e.illegal = ill;
        e.retired = exp_ret;
        q.push_back(e);
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [2:0] ralu);
        logic [3:0] seq[$];
        logic       ill;
        ill = 1'b0;
        case (o)
            6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
            6'b000100: seq = '{4'd0, 4'd1, 4'd8};
            6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
            6'b000010: seq = '{4'd0, 4'd1, 4'd11};
`ifdef MC_CONTROL_BNE_EN
            6'b000101: seq = '{4'd0, 4'd1, 4'd12};
`endif
            default: begin seq = '{4'd0, 4'd1}; ill = 1'b1; end
        endcase
        op = o;
        funct = f;
        zero = z;
        foreach (seq[i]) push(seq[i], z, ralu, (i == 0) ? pend_ill : 1'b0);
        pend_ill = ill;
        if (!ill) exp_ret++;
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            a = {state_dbg, iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal_op, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle st=%0d got=%h exp=%h", e.st, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_state", 32'(state_dbg), 0);
            chk("rst_retired", retired, 0);
            chk("rst_pcen", 32'(pcen), 0);
            chk("rst_irwrite", 32'(irwrite), 0);
        end
        reset = 1'b0;
        run(6'b100011, 6'b000000, 1'b0, 3'b010);
        run(6'b101011, 6'b000000, 1'b0, 3'b010);
        run(6'b000000, 6'b100010, 1'b0, 3'b110);
        run(6'b000000, 6'b100000, 1'b0, 3'b010);
        run(6'b000000, 6'b100100, 1'b0, 3'b000);
        run(6'b000000, 6'b101010, 1'b0, 3'b111);
        run(6'b000000, 6'b000111, 1'b0, 3'b010);
        run(6'b000100, 6'b000000, 1'b1, 3'b010);
        run(6'b000100, 6'b000000, 1'b0, 3'b010);
        run(6'b001000, 6'b000000, 1'b0, 3'b010);
        run(6'b000010, 6'b000000, 1'b1, 3'b010);
        run(6'b111111, 6'b000000, 1'b0, 3'b010);
        run(6'b000101, 6'b000000, 1'b0, 3'b010);
        run(6'b000101, 6'b000000, 1'b1, 3'b010);
        run(6'b100011, 6'b000000, 1'b0, 3'b010);
        chk("retired_total", retired, exp_ret);
        op = 6'b101011;
        push(4'd0, 1'b0, 3'b010, pend_ill);
        push(4'd1, 1'b0, 3'b010, 1'b0);
        push(4'd2, 1'b0, 3'b010, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_memwrite", 32'(memwrite), 1);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", 32'(memwrite), 0);
        chk("abort_regwrite", 32'(regwrite), 0);
        chk("abort_state", 32'(state_dbg), 0);
        chk("abort_retired", retired, 0);
        chk("abort_illegal", 32'(illegal_op), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = '0;
        pend_ill = 1'b0;
        run(6'b000000, 6'b100101, 1'b0, 3'b001);
        run(6'b001000, 6'b000000, 1'b0, 3'b010);
        chk("q_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
